// File: rtl/svpwm_pwm_gen.sv
// rtl/svpwm_pwm_gen.sv - centre-aligned three-phase PWM with double-buffered compares and dead band
// Carrier, Q15-to-count scaling, zero-aligned compare load and per-phase dead-band gate drive.
module svpwm_pwm_gen #(
  parameter int PWM_PERIOD = 2500,
  parameter int DEAD_TIME  = 50,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        pwm_enable_in,
  input  logic [15:0] Tcma_in,
  input  logic [15:0] Tcmb_in,
  input  logic [15:0] Tcmc_in,
  input  logic        svpwm_cal_done_in,
  output logic        pwm_ah_out,
  output logic        pwm_al_out,
  output logic        pwm_bh_out,
  output logic        pwm_bl_out,
  output logic        pwm_ch_out,
  output logic        pwm_cl_out,
  output logic        carrier_zero_out,
  output logic        carrier_dir_out,
  output logic        cmp_update_out
);

  localparam logic [CNT_WIDTH-1:0] LP_PERIOD = CNT_WIDTH'(PWM_PERIOD);
  localparam logic [7:0]           LP_DEAD   = 8'(DEAD_TIME);

  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [CNT_WIDTH-1:0]      w_cnt_nxt;
  logic                      r_dir;
  logic                      w_dir_nxt;
  logic                      r_zero;
  logic                      r_pending;
  logic                      r_en_d;
  logic                      w_load;
  logic [2:0][15:0]          w_tcm;
  logic [2:0][CNT_WIDTH-1:0] w_scaled;
  logic [2:0][CNT_WIDTH-1:0] r_shadow;
  logic [2:0][CNT_WIDTH-1:0] r_active;
  logic [2:0]                r_ideal;
  logic [2:0]                r_ideal_d;
  logic [2:0]                r_gh;
  logic [2:0]                r_gl;
  logic [2:0][7:0]           r_db;

  // Negative switching times clamp to zero compare (full duty).
  function automatic logic [CNT_WIDTH-1:0] f_scale(input logic [15:0] t);
    logic [30:0] prod;
    prod = {16'd0, t[14:0]} * 31'(PWM_PERIOD);
    return t[15] ? '0 : CNT_WIDTH'(prod >> 15);
  endfunction

  assign w_tcm = {Tcmc_in, Tcmb_in, Tcma_in};

  always_comb begin
    w_scaled = '0;
    for (int i = 0; i < 3; i++) w_scaled[i] = f_scale(w_tcm[i]);
  end

  always_comb begin
    w_cnt_nxt = r_dir ? r_cnt + 1'b1 : r_cnt - 1'b1;
    w_dir_nxt = r_dir;
    if (r_dir && (w_cnt_nxt == LP_PERIOD)) w_dir_nxt = 1'b0;
    else if (!r_dir && (w_cnt_nxt == '0)) w_dir_nxt = 1'b1;
  end

  // r_zero is a look-ahead of cnt==0 so the zero pulse and the load share one cycle.
  assign w_load = r_zero & r_pending;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_dir     <= 1'b1;
      r_zero    <= 1'b0;
      r_pending <= 1'b0;
      r_en_d    <= 1'b0;
      r_shadow  <= {3{LP_PERIOD}};
      r_active  <= {3{LP_PERIOD}};
      r_ideal   <= '0;
      r_ideal_d <= '0;
      r_gh      <= '0;
      r_gl      <= '0;
      r_db      <= {3{LP_DEAD}};
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_zero    <= (w_cnt_nxt == '0);
      r_en_d    <= pwm_enable_in;
      r_ideal_d <= r_ideal;
      // A fresh done pulse wins over the clear from a simultaneous load.
      if (svpwm_cal_done_in) begin
        r_shadow  <= w_scaled;
        r_pending <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
      if (w_load) r_active <= r_shadow;
      for (int i = 0; i < 3; i++) begin
        r_ideal[i] <= (r_cnt > r_active[i]);
        if (!pwm_enable_in) begin
          r_gh[i] <= 1'b0;
          r_gl[i] <= 1'b0;
          r_db[i] <= LP_DEAD;
        end else if ((LP_DEAD != 8'd0) && ((r_ideal[i] != r_ideal_d[i]) || !r_en_d)) begin
          r_gh[i] <= 1'b0;
          r_gl[i] <= 1'b0;
          r_db[i] <= 8'd1;
        end else if (r_db[i] < LP_DEAD) begin
          r_gh[i] <= 1'b0;
          r_gl[i] <= 1'b0;
          r_db[i] <= r_db[i] + 8'd1;
        end else begin
          r_gh[i] <= r_ideal[i];
          r_gl[i] <= ~r_ideal[i];
        end
      end
    end
  end

  assign pwm_ah_out       = r_gh[0];
  assign pwm_al_out       = r_gl[0];
  assign pwm_bh_out       = r_gh[1];
  assign pwm_bl_out       = r_gl[1];
  assign pwm_ch_out       = r_gh[2];
  assign pwm_cl_out       = r_gl[2];
  assign carrier_zero_out = r_zero;
  assign carrier_dir_out  = r_dir;
  assign cmp_update_out   = w_load;

endmodule

// File: tb/tb_svpwm_pwm_gen.sv
// tb/tb_svpwm_pwm_gen.sv - self-checking bench for svpwm_pwm_gen
// Vector table of switching times feeds a scoreboard of expected compares; gate duty is measured per period.
module tb_svpwm_pwm_gen;
  localparam int P = 100;
  localparam int D = 3;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_enable_in = 1'b1;
  logic [15:0] tcma = '0, tcmb = '0, tcmc = '0;
  logic        done = 1'b0;
  logic        pwm_ah_out, pwm_al_out, pwm_bh_out, pwm_bl_out, pwm_ch_out, pwm_cl_out;
  logic        carrier_zero_out, carrier_dir_out, cmp_update_out;
  logic [5:0]  gates;

  svpwm_pwm_gen #(.PWM_PERIOD(P), .DEAD_TIME(D), .CNT_WIDTH(16)) dut (
    .sys_clk(sys_clk), .reset(reset), .pwm_enable_in(pwm_enable_in),
    .Tcma_in(tcma), .Tcmb_in(tcmb), .Tcmc_in(tcmc), .svpwm_cal_done_in(done),
    .pwm_ah_out(pwm_ah_out), .pwm_al_out(pwm_al_out),
    .pwm_bh_out(pwm_bh_out), .pwm_bl_out(pwm_bl_out),
    .pwm_ch_out(pwm_ch_out), .pwm_cl_out(pwm_cl_out),
    .carrier_zero_out(carrier_zero_out), .carrier_dir_out(carrier_dir_out),
    .cmp_update_out(cmp_update_out)
  );

  assign gates = {pwm_ah_out, pwm_al_out, pwm_bh_out, pwm_bl_out, pwm_ch_out, pwm_cl_out};

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] ta, tb, tc;
    int          ca, cb, cc;
  } vec_t;
  typedef struct {
    int ca, cb, cc;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  int   mcnt = 0;
  bit   mdir = 1'b1;
  bit   mfirst = 1'b1;
  bit   mon_on = 1'b0;
  int   err_car = 0, err_ovl = 0, err_upd = 0;

  // Reference carrier, advanced on the same edge as the DUT.
  always @(posedge sys_clk) begin
    if (reset) begin
      mcnt <= 0; mdir <= 1'b1; mfirst <= 1'b1;
    end else begin
      mfirst <= 1'b0;
      if (mdir) begin
        mcnt <= mcnt + 1;
        if (mcnt + 1 == P) mdir <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
        if (mcnt - 1 == 0) mdir <= 1'b1;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (mon_on) begin
      if (carrier_zero_out !== (mfirst ? 1'b0 : (mcnt == 0)) || carrier_dir_out !== mdir)
        err_car <= err_car + 1;
      if ((pwm_ah_out & pwm_al_out) | (pwm_bh_out & pwm_bl_out) | (pwm_ch_out & pwm_cl_out))
        err_ovl <= err_ovl + 1;
      if (cmp_update_out && !carrier_zero_out)
        err_upd <= err_upd + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic exp_t mk_exp(input int a, input int b, input int c);
    exp_t e;
    e.ca = a; e.cb = b; e.cc = c;
    return e;
  endfunction

  function automatic int hi_cycles(input int cmp);
    return (cmp >= P) ? 0 : 2 * (P - cmp) - 1;
  endfunction

  function automatic int exp_h(input int cmp);
    int h;
    h = hi_cycles(cmp);
    return (h > D) ? h - D : 0;
  endfunction

  function automatic int exp_l(input int cmp);
    int h;
    h = hi_cycles(cmp);
    if (h == 0) return 2 * P;
    return (2 * P - h > D) ? 2 * P - h - D : 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_done(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    tcma = a; tcmb = b; tcmc = c; done = 1'b1;
    @(negedge sys_clk);
    done = 1'b0;
  endtask

  task automatic wait_update(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6 * P; i++) begin
      @(negedge sys_clk);
      if (cmp_update_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cnt(input int c, input bit d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge sys_clk);
      if (mcnt == c && mdir == d) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_counts(input string tag, input exp_t e);
    int n[6];
    for (int k = 0; k < 6; k++) n[k] = 0;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge sys_clk);
      n[0] += int'(pwm_ah_out); n[1] += int'(pwm_al_out);
      n[2] += int'(pwm_bh_out); n[3] += int'(pwm_bl_out);
      n[4] += int'(pwm_ch_out); n[5] += int'(pwm_cl_out);
    end
    check({tag, "_ah"}, n[0], exp_h(e.ca));
    check({tag, "_al"}, n[1], exp_l(e.ca));
    check({tag, "_bh"}, n[2], exp_h(e.cb));
    check({tag, "_bl"}, n[3], exp_l(e.cb));
    check({tag, "_ch"}, n[4], exp_h(e.cc));
    check({tag, "_cl"}, n[5], exp_l(e.cc));
  endtask

  initial begin
    bit   ok;
    int   nz, nupd, first_upd;
    exp_t e;

    vecs[0] = '{16'h4000, 16'h0000, 16'h7fff, 50, 0, 99};
    vecs[1] = '{16'h8000, 16'h2000, 16'h6000, 0, 25, 75};
    vecs[2] = '{16'h7fff, 16'h4000, 16'hffff, 99, 50, 0};
    vecs[3] = '{16'h1000, 16'h0001, 16'h7ffe, 12, 0, 99};

    reset = 1'b1;
    tick(3);
    check("rst_gates", int'(gates), 0);
    check("rst_zero", int'(carrier_zero_out), 0);
    check("rst_upd", int'(cmp_update_out), 0);
    check("rst_dir", int'(carrier_dir_out), 1);
    reset = 1'b0;
    mon_on = 1'b1;
    tick(2 * P);
    check_counts("rst_duty", mk_exp(P, P, P));

    for (int v = 0; v < 4; v++) begin
      drive_done(vecs[v].ta, vecs[v].tb, vecs[v].tc);
      sb.push_back(mk_exp(vecs[v].ca, vecs[v].cb, vecs[v].cc));
      wait_update(ok);
      e = sb.pop_front();
      if (!ok) timeout_fail($sformatf("vec%0d_update", v));
      else begin
        tick(2 * P);
        check_counts($sformatf("vec%0d", v), e);
      end
    end

    // Done coincident with zero, then overwritten before the following zero.
    ok = 1'b0;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge sys_clk);
      if (carrier_zero_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("coinc_zero");
    check("coinc_upd", int'(cmp_update_out), 0);
    tcma = 16'h6000; tcmb = 16'h1000; tcmc = 16'h4000; done = 1'b1;
    first_upd = -1;
    nupd = 0;
    for (int i = 1; i < 4 * P; i++) begin
      @(negedge sys_clk);
      if (i == 1) done = 1'b0;
      if (i == 50) begin
        tcma = 16'h2000; tcmb = 16'h7fff; tcmc = 16'h8000; done = 1'b1;
        sb.push_back(mk_exp(25, 99, 0));
      end
      if (i == 51) done = 1'b0;
      if (cmp_update_out) begin
        nupd++;
        if (first_upd < 0) first_upd = i;
      end
    end
    check("coinc_latency", first_upd, 2 * P);
    check("coinc_nupd", nupd, 1);
    e = sb.pop_front();
    check_counts("last_wins", e);

    // Enable drop mid-period and re-enable.
    wait_cnt(40, 1'b1, ok);
    if (!ok) timeout_fail("dis_wait");
    pwm_enable_in = 1'b0;
    nz = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge sys_clk);
      if (j == 1) check("dis_next", int'(gates), 0);
      else if (gates != 6'd0) nz++;
    end
    check("dis_hold", nz, 0);
    pwm_enable_in = 1'b1;
    nz = 0;
    for (int j = 1; j <= D; j++) begin
      @(negedge sys_clk);
      if (gates != 6'd0) nz++;
    end
    check("reen_band", nz, 0);
    @(negedge sys_clk);
    check("reen_follow", int'(gates), 6'b100110);

    // Reset while counting down at 73 with a load pending.
    wait_cnt(80, 1'b0, ok);
    if (!ok) timeout_fail("rst6_wait80");
    drive_done(16'h4000, 16'h4000, 16'h4000);
    wait_cnt(73, 1'b0, ok);
    if (!ok) timeout_fail("rst6_wait73");
    reset = 1'b1;
    @(negedge sys_clk);
    check("rst6_state", int'({gates, carrier_zero_out, cmp_update_out, carrier_dir_out}), 1);
    reset = 1'b0;
    nupd = 0;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge sys_clk);
      if (cmp_update_out) nupd++;
    end
    check("rst6_noupd", nupd, 0);
    check_counts("rst6_duty", mk_exp(P, P, P));

    tick(2);
    check("mon_carrier", err_car, 0);
    check("mon_overlap", err_ovl, 0);
    check("mon_update", err_upd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
